scene_pixel_renderer: RTL and testbench

- Parametrised successor to the running-state pixel renderer; serves the VGA pixel stream in the game datapath.
- Composites ground, dino sprite and NUM_OBS obstacles into one COLOR_W-bit colour per requested pixel.
- 2-stage pipeline, with a synchronous sprite-ROM lookup.
- Object positions are double-buffered and latched once per frame, so mid-frame game-logic updates never tear.

---
 rtl/scene_pixel_renderer_pkg.sv | 25 ++
 rtl/scene_pixel_renderer_obstacle_hit.sv | 49 ++++
 rtl/scene_pixel_renderer.sv | 216 +++++++++++++++++++++
 tb/tb_scene_pixel_renderer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_pixel_renderer_pkg.sv
// Shared game constants for the scene pixel renderer: geometry, colours and
// the obstacle colour-select rule.
package scene_pixel_renderer_pkg;

    localparam int DEF_NUM_OBS    = 2;
    localparam int DEF_COORD_W    = 8;
    localparam int DEF_COLOR_W    = 3;
    localparam int DEF_GROUND_TOP = 100;
    localparam int DEF_DINO_LEFT  = 10;
    localparam int DEF_DINO_W     = 16;
    localparam int DEF_DINO_H     = 16;
    localparam int DEF_OBS_W      = 8;

    localparam logic [2:0] DEF_COL_BG          = 3'b111;
    localparam logic [2:0] DEF_COL_GRND        = 3'b000;
    localparam logic [2:0] DEF_COL_OBS_A       = 3'b010;
    localparam logic [2:0] DEF_COL_OBS_B       = 3'b100;
    localparam logic [2:0] DEF_COL_TRANSPARENT = 3'b101;

    // Odd-indexed obstacles use the B colour, even-indexed ones the A colour.
    function automatic logic obs_uses_col_b(input int idx);
        return idx[0];
    endfunction

endpackage

// File: rtl/scene_pixel_renderer_obstacle_hit.sv
// Single-channel obstacle hit test. Bounds are evaluated one bit wider than
// the coordinates so an obstacle straddling the right edge never wraps, and
// the obstacle top is clamped at row 0 for heights above the ground line.
module scene_obstacle_hit
    import scene_pixel_renderer_pkg::*;
#(
    parameter int COORD_W    = DEF_COORD_W,
    parameter int GROUND_TOP = DEF_GROUND_TOP,
    parameter int OBS_W      = DEF_OBS_W
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] ox_i,
    input  logic [COORD_W-1:0] oh_i,
    input  logic               en_i,
    output logic               hit_o
);

    localparam logic [COORD_W:0] GT_EXT = (COORD_W+1)'(GROUND_TOP);
    localparam logic [COORD_W:0] OW_EXT = (COORD_W+1)'(OBS_W);

    logic [COORD_W:0] x_ext_s;
    logic [COORD_W:0] y_ext_s;
    logic [COORD_W:0] ox_ext_s;
    logic [COORD_W:0] oh_ext_s;
    logic [COORD_W:0] right_s;
    logic [COORD_W:0] top_s;

    // Widened column window, clamped top row and the resulting hit flag.
    always_comb begin
        x_ext_s  = {1'b0, x_i};
        y_ext_s  = {1'b0, y_i};
        ox_ext_s = {1'b0, ox_i};
        oh_ext_s = {1'b0, oh_i};
        right_s  = ox_ext_s + OW_EXT;
        if (oh_ext_s > GT_EXT) begin
            top_s = {(COORD_W+1){1'b0}};
        end else begin
            top_s = GT_EXT - oh_ext_s;
        end
        if (en_i && (oh_i != {COORD_W{1'b0}}) && (x_ext_s >= ox_ext_s) &&
            (x_ext_s < right_s) && (y_ext_s >= top_s)) begin
            hit_o = 1'b1;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/scene_pixel_renderer.sv
// Scene pixel renderer: composites ground, dino sprite and NUM_OBS obstacles
// into one colour per requested pixel through a 2-stage pipeline. Object
// positions are shadowed once per frame (with same-cycle bypass).
// Optional build macro: SCENE_COLLISION_DETECT_EN adds a sticky collision flag.
module scene_pixel_renderer
    import scene_pixel_renderer_pkg::*;
#(
    parameter int NUM_OBS    = DEF_NUM_OBS,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int GROUND_TOP = DEF_GROUND_TOP,
    parameter int DINO_LEFT  = DEF_DINO_LEFT,
    parameter int DINO_W     = DEF_DINO_W,
    parameter int DINO_H     = DEF_DINO_H,
    parameter int OBS_W      = DEF_OBS_W,
    parameter logic [COLOR_W-1:0] COL_BG          = DEF_COL_BG,
    parameter logic [COLOR_W-1:0] COL_GRND        = DEF_COL_GRND,
    parameter logic [COLOR_W-1:0] COL_OBS_A       = DEF_COL_OBS_A,
    parameter logic [COLOR_W-1:0] COL_OBS_B       = DEF_COL_OBS_B,
    parameter logic [COLOR_W-1:0] COL_TRANSPARENT = DEF_COL_TRANSPARENT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       frame_start,
    input  logic                       px_valid,
    input  logic [COORD_W-1:0]         x,
    input  logic [COORD_W-1:0]         y,
    input  logic [COORD_W-1:0]         dino_y,
    input  logic [NUM_OBS*COORD_W-1:0] obs_x,
    input  logic [NUM_OBS*COORD_W-1:0] obs_h,
    input  logic [NUM_OBS-1:0]         obs_en,
    output logic [COORD_W-1:0]         sprite_addr_x,
    output logic [COORD_W-1:0]         sprite_addr_y,
    input  logic [COLOR_W-1:0]         sprite_color,
    output logic [COLOR_W-1:0]         color,
`ifdef SCENE_COLLISION_DETECT_EN
    output logic                       collision,
`endif
    output logic                       color_valid
);

    localparam logic [COORD_W:0] GT_EXT = (COORD_W+1)'(GROUND_TOP);
    localparam logic [COORD_W:0] DL_EXT = (COORD_W+1)'(DINO_LEFT);
    localparam logic [COORD_W:0] DR_EXT = (COORD_W+1)'(DINO_LEFT + DINO_W);
    localparam logic [COORD_W:0] DH_EXT = (COORD_W+1)'(DINO_H);

    // Shadow registers; the _d values double as the bypassed effective values.
    logic [COORD_W-1:0]         dino_y_q, dino_y_d;
    logic [NUM_OBS*COORD_W-1:0] obs_x_q, obs_x_d;
    logic [NUM_OBS*COORD_W-1:0] obs_h_q, obs_h_d;
    logic [NUM_OBS-1:0]         obs_en_q, obs_en_d;

    // Stage 1 state.
    logic               v1_q, v1_d;
    logic               grnd1_q, grnd1_d;
    logic               dino1_q, dino1_d;
    logic [NUM_OBS-1:0] obs_hit1_q, obs_hit1_d;
    logic [COORD_W-1:0] addr_x_q, addr_x_d;
    logic [COORD_W-1:0] addr_y_q, addr_y_d;

    // Stage 2 state.
    logic [COLOR_W-1:0] color_q, color_d;
    logic               color_valid_q, color_valid_d;

    logic [NUM_OBS-1:0] obs_hit_s;
    logic [COORD_W:0]   x_ext_s, y_ext_s, dy_ext_s;
    logic               ground_s, dino_hit_s, opaque_s;
    logic [COLOR_W-1:0] obs_col_s, compose_s;

    // Shadow update on frame_start; otherwise hold.
    always_comb begin
        if (frame_start) begin
            dino_y_d = dino_y;
            obs_x_d  = obs_x;
            obs_h_d  = obs_h;
            obs_en_d = obs_en;
        end else begin
            dino_y_d = dino_y_q;
            obs_x_d  = obs_x_q;
            obs_h_d  = obs_h_q;
            obs_en_d = obs_en_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OBS; gi++) begin : g_obs
            scene_obstacle_hit #(
                .COORD_W   (COORD_W),
                .GROUND_TOP(GROUND_TOP),
                .OBS_W     (OBS_W)
            ) u_hit (
                .x_i  (x),
                .y_i  (y),
                .ox_i (obs_x_d[gi*COORD_W +: COORD_W]),
                .oh_i (obs_h_d[gi*COORD_W +: COORD_W]),
                .en_i (obs_en_d[gi]),
                .hit_o(obs_hit_s[gi])
            );
        end
    endgenerate

    // Stage 1: ground/dino tests, sprite address and capture of the request.
    always_comb begin
        x_ext_s    = {1'b0, x};
        y_ext_s    = {1'b0, y};
        dy_ext_s   = {1'b0, dino_y_d};
        ground_s   = (y_ext_s >= GT_EXT);
        dino_hit_s = (x_ext_s >= DL_EXT) && (x_ext_s < DR_EXT) &&
                     (y_ext_s >= dy_ext_s) && (y_ext_s < (dy_ext_s + DH_EXT));
        v1_d       = px_valid;
        if (px_valid) begin
            grnd1_d    = ground_s;
            dino1_d    = dino_hit_s;
            obs_hit1_d = obs_hit_s;
            addr_x_d   = x - COORD_W'(DINO_LEFT);
            addr_y_d   = y - dino_y_d;
        end else begin
            grnd1_d    = grnd1_q;
            dino1_d    = dino1_q;
            obs_hit1_d = obs_hit1_q;
            addr_x_d   = addr_x_q;
            addr_y_d   = addr_y_q;
        end
    end

    // Stage 2: fixed-priority compose; colour holds when no pixel arrives.
    always_comb begin
        opaque_s  = dino1_q && (sprite_color != COL_TRANSPARENT);
        obs_col_s = COL_BG;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (obs_hit1_q[i]) begin
                obs_col_s = obs_uses_col_b(i) ? COL_OBS_B : COL_OBS_A;
            end else begin
                obs_col_s = obs_col_s;
            end
        end
        if (grnd1_q) begin
            compose_s = COL_GRND;
        end else if (opaque_s) begin
            compose_s = sprite_color;
        end else begin
            compose_s = obs_col_s;
        end
        color_valid_d = v1_q;
        if (v1_q) begin
            color_d = compose_s;
        end else begin
            color_d = color_q;
        end
    end

    // Shadow, stage-1 and stage-2 registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dino_y_q      <= {COORD_W{1'b0}};
            obs_x_q       <= {(NUM_OBS*COORD_W){1'b0}};
            obs_h_q       <= {(NUM_OBS*COORD_W){1'b0}};
            obs_en_q      <= {NUM_OBS{1'b0}};
            v1_q          <= 1'b0;
            grnd1_q       <= 1'b0;
            dino1_q       <= 1'b0;
            obs_hit1_q    <= {NUM_OBS{1'b0}};
            addr_x_q      <= {COORD_W{1'b0}};
            addr_y_q      <= {COORD_W{1'b0}};
            color_q       <= COL_BG;
            color_valid_q <= 1'b0;
        end else begin
            dino_y_q      <= dino_y_d;
            obs_x_q       <= obs_x_d;
            obs_h_q       <= obs_h_d;
            obs_en_q      <= obs_en_d;
            v1_q          <= v1_d;
            grnd1_q       <= grnd1_d;
            dino1_q       <= dino1_d;
            obs_hit1_q    <= obs_hit1_d;
            addr_x_q      <= addr_x_d;
            addr_y_q      <= addr_y_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign sprite_addr_x = addr_x_q;
    assign sprite_addr_y = addr_y_q;
    assign color         = color_q;
    assign color_valid   = color_valid_q;

`ifdef SCENE_COLLISION_DETECT_EN
    logic collision_q, collision_d;

    // Sticky collision: set by an opaque dino pixel over any obstacle, cleared
    // by frame_start, with set taking precedence.
    always_comb begin
        if (v1_q && opaque_s && (|obs_hit1_q)) begin
            collision_d = 1'b1;
        end else if (frame_start) begin
            collision_d = 1'b0;
        end else begin
            collision_d = collision_q;
        end
    end

    // Collision flag register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`endif

endmodule

// File: tb/tb_scene_pixel_renderer.sv
// Self-checking bench for scene_pixel_renderer: directed scenes plus random
// traffic against a per-pixel scene model. Build with SCENE_COLLISION_DETECT_EN
// to also check the collision flag.
module tb_scene_pixel_renderer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_start;
    logic        px_valid;
    logic [7:0]  x, y, dino_y;
    logic [15:0] obs_x, obs_h;
    logic [1:0]  obs_en;
    logic [7:0]  sprite_addr_x, sprite_addr_y;
    logic [2:0]  sprite_color;
    logic [2:0]  color;
    logic        color_valid;
`ifdef SCENE_COLLISION_DETECT_EN
    logic        collision;
`endif

    always #5 clk = ~clk;

    scene_pixel_renderer dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .px_valid     (px_valid),
        .x            (x),
        .y            (y),
        .dino_y       (dino_y),
        .obs_x        (obs_x),
        .obs_h        (obs_h),
        .obs_en       (obs_en),
        .sprite_addr_x(sprite_addr_x),
        .sprite_addr_y(sprite_addr_y),
        .sprite_color (sprite_color),
        .color        (color),
`ifdef SCENE_COLLISION_DETECT_EN
        .collision    (collision),
`endif
        .color_valid  (color_valid)
    );

    // Sprite ROM: 16x16 entries, row-major, read from the registered address.
    logic [2:0] rom_mem [0:255];
    assign sprite_color = rom_mem[{sprite_addr_y[3:0], sprite_addr_x[3:0]}];

    int n_checks = 0;
    int n_fail   = 0;

    // Scene inputs as the game logic would present them.
    int in_dy;
    int in_ox [2];
    int in_oh [2];
    bit in_en [2];

    // Model: latched shadows, effective (bypassed) values, output history.
    int m_dy;
    int m_ox [2];
    int m_oh [2];
    bit m_en [2];
    int e_dy;
    int e_ox [2];
    int e_oh [2];
    bit e_en [2];
    logic [2:0] m_col;
    bit m_coll;
    bit p_v;
    logic [2:0] p_c;
    bit p_evt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_scene();
        dino_y = 8'(in_dy);
        for (int i = 0; i < 2; i++) begin
            obs_x[i*8 +: 8] = 8'(in_ox[i]);
            obs_h[i*8 +: 8] = 8'(in_oh[i]);
            obs_en[i]       = in_en[i];
        end
    endtask

    // Scene rules in plain integer arithmetic against the effective objects.
    function automatic void model_pixel(input int px, input int py,
                                        output logic [2:0] c, output bit evt);
        bit ground, dino, opaque;
        int first, top;
        logic [2:0] rom_val;
        ground = (py >= 100);
        dino   = (px >= 10) && (px < 26) && (py >= e_dy) && (py < e_dy + 16);
        rom_val = dino ? rom_mem[(py - e_dy) * 16 + (px - 10)] : 3'b000;
        opaque = dino && (rom_val != 3'b101);
        first = -1;
        for (int i = 0; i < 2; i++) begin
            top = 100 - e_oh[i];
            if (top < 0) top = 0;
            if (first < 0 && e_en[i] && e_oh[i] > 0 && px >= e_ox[i] &&
                px < e_ox[i] + 8 && py >= top) first = i;
        end
        if (ground)          c = 3'b000;
        else if (opaque)     c = rom_val;
        else if (first == 1) c = 3'b100;
        else if (first == 0) c = 3'b010;
        else                 c = 3'b111;
        evt = opaque && (first >= 0);
    endfunction

    // One clock: drive a request, advance the model, check the outputs.
    task automatic cyc(input bit fs, input bit pv, input int px, input int py);
        logic [2:0] c;
        bit evt;
        drive_scene();
        frame_start = fs;
        px_valid    = pv;
        x           = 8'(px);
        y           = 8'(py);
        e_dy = fs ? in_dy : m_dy;
        for (int i = 0; i < 2; i++) begin
            e_ox[i] = fs ? in_ox[i] : m_ox[i];
            e_oh[i] = fs ? in_oh[i] : m_oh[i];
            e_en[i] = fs ? in_en[i] : m_en[i];
        end
        c = 3'b111;
        evt = 1'b0;
        if (pv) model_pixel(px, py, c, evt);
        @(posedge clk);
        if (p_v) m_col = p_c;
        if (p_evt) m_coll = 1'b1;
        else if (fs) m_coll = 1'b0;
        if (fs) begin
            m_dy = in_dy;
            for (int i = 0; i < 2; i++) begin
                m_ox[i] = in_ox[i]; m_oh[i] = in_oh[i]; m_en[i] = in_en[i];
            end
        end
        @(negedge clk);
        check_eq("color_valid", 32'(color_valid), 32'(p_v));
        check_eq("color", 32'(color), 32'(m_col));
`ifdef SCENE_COLLISION_DETECT_EN
        check_eq("collision", 32'(collision), 32'(m_coll));
`endif
        p_v   = pv;
        p_c   = c;
        p_evt = pv && evt;
    endtask

    // One clock with resetn low and a live request that must be discarded.
    task automatic rst_cyc();
        resetn      = 1'b0;
        frame_start = 1'($urandom_range(0, 1));
        px_valid    = 1'b1;
        x           = 8'($urandom_range(0, 255));
        y           = 8'($urandom_range(0, 255));
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_color_valid", 32'(color_valid), 32'd0);
        check_eq("rst_color", 32'(color), 32'h7);
        check_eq("rst_addr", 32'({sprite_addr_x, sprite_addr_y}), 32'd0);
`ifdef SCENE_COLLISION_DETECT_EN
        check_eq("rst_collision", 32'(collision), 32'd0);
`endif
        m_dy = 0;
        for (int i = 0; i < 2; i++) begin
            m_ox[i] = 0; m_oh[i] = 0; m_en[i] = 1'b0;
        end
        m_col = 3'b111; m_coll = 1'b0; p_v = 1'b0; p_evt = 1'b0; p_c = 3'b111;
    endtask

    task automatic flush();
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 3'b101 : 3'($urandom_range(0, 7));
        end
        in_dy = 84;
        for (int i = 0; i < 2; i++) begin
            in_ox[i] = 0; in_oh[i] = 0; in_en[i] = 1'b0;
        end
        drive_scene();
        resetn = 1'b0; frame_start = 1'b0; px_valid = 1'b0; x = 8'd0; y = 8'd0;
        @(negedge clk);

        // Reset with requests pending, then release.
        repeat (3) rst_cyc();
        resetn = 1'b1;
        cyc(1'b0, 1'b1, 200, 20);
        cyc(1'b0, 1'b0, 0, 0);

        // Ground stream and latency.
        cyc(1'b1, 1'b1, 0, 100);
        for (int i = 1; i < 6; i++) cyc(1'b0, 1'b1, i, 100);
        flush();

        // Priority: opaque dino over obstacle, transparent dino shows through.
        in_dy = 84; in_ox[0] = 12; in_oh[0] = 16; in_en[0] = 1'b1;
        rom_mem[5*16+5] = 3'b001;
        cyc(1'b1, 1'b1, 15, 89);
        flush();
        rom_mem[5*16+5] = 3'b101;
        cyc(1'b0, 1'b1, 15, 89);
        flush();
        in_oh[0] = 10;
        cyc(1'b1, 1'b1, 15, 89);
        flush();
        cyc(1'b1, 1'b0, 0, 0);
        flush();

        // Tearing and bypass.
        in_ox[0] = 40; in_oh[0] = 10; in_en[0] = 1'b1;
        cyc(1'b1, 1'b0, 0, 0);
        in_ox[0] = 60;
        cyc(1'b0, 1'b1, 45, 95);
        cyc(1'b1, 1'b1, 45, 95);
        flush();

        // Right-edge no-wrap and tall-obstacle clamp.
        in_en[0] = 1'b0; in_ox[1] = 252; in_oh[1] = 10; in_en[1] = 1'b1;
        cyc(1'b1, 1'b1, 255, 95);
        cyc(1'b0, 1'b1, 2, 95);
        in_oh[1] = 200;
        cyc(1'b1, 1'b1, 252, 0);
        flush();

        // Opaque dino over obstacle: sticky flag until the next frame.
        rom_mem[5*16+5] = 3'b011;
        in_ox[0] = 12; in_oh[0] = 16; in_en[0] = 1'b1; in_en[1] = 1'b0;
        cyc(1'b1, 1'b1, 15, 89);
        repeat (4) cyc(1'b0, 1'b1, 200, 20);
        cyc(1'b1, 1'b0, 0, 0);
        flush();

        // Random traffic with mid-frame object updates.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_cyc();
                resetn = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                in_dy = $urandom_range(60, 110);
                for (int i = 0; i < 2; i++) begin
                    in_ox[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(0, 255);
                    in_oh[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 200);
                    in_en[i] = 1'($urandom_range(0, 1));
                end
            end
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(0, 255),
                ($urandom_range(0, 1) == 1) ? $urandom_range(60, 130) : $urandom_range(0, 255));
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
